// File: rtl/i2s_feeder.sv
// i2s_feeder: stereo-frame FIFO that feeds an I2S transmitter through a
// send/ready handshake. Each popped frame is held on send_queue_left/right
// and announced with a one-cycle send pulse.
// Build option: define I2S_FEEDER_UNDERRUN_EN to send mute frames and count
// underruns when the FIFO runs dry after the first real frame.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for the transmitter to be ready and a frame to send
// SEND       | send pulse high; the popped frame is on send_queue_left/right
// WAIT_BUSY  | waiting for the transmitter to drop ready (frame accepted)
// WAIT_READY | waiting for the transmitter to raise ready again

module i2s_feeder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_left,
    input  logic [WIDTH-1:0]         in_right,
    output logic                     in_ready,
    input  logic                     i2s_ready,
    output logic                     send,
    output logic [WIDTH-1:0]         send_queue_left,
    output logic [WIDTH-1:0]         send_queue_right,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               underruns
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND       = 2'd1,
        WAIT_BUSY  = 2'd2,
        WAIT_READY = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      fill;
    logic               push;
    logic               pop;
    logic               mute;

`ifdef I2S_FEEDER_UNDERRUN_EN
    logic               primed;
    logic [7:0]         underrun_cnt;
`endif

    assign in_ready = (fill != FULL);
    assign push     = in_valid && in_ready;
    assign count    = fill;
    // send is a pure state decode, so it drops immediately with reset
    assign send     = (state == SEND);

    // next-state decode; pop and mute are the two ways of leaving IDLE
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        mute      = 1'b0;
        case (state)
            IDLE: begin
                if (i2s_ready) begin
                    if (fill != '0) begin
                        pop       = 1'b1;
                        state_nxt = SEND;
                    end
`ifdef I2S_FEEDER_UNDERRUN_EN
                    else if (primed) begin
                        mute      = 1'b1;
                        state_nxt = SEND;
                    end
`endif
                end
            end
            SEND:       state_nxt = WAIT_BUSY;
            WAIT_BUSY:  if (!i2s_ready) state_nxt = WAIT_READY;
            WAIT_READY: if (i2s_ready)  state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // frame storage; contents are don't-care until written, pointers guard them
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_left, in_right};
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fill <= fill + CW'(1);
                2'b01:   fill <= fill - CW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // output frame holds from one pop (or mute) to the next
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            send_queue_left  <= '0;
            send_queue_right <= '0;
        end else if (pop) begin
            send_queue_left  <= mem[rd_ptr][2*WIDTH-1:WIDTH];
            send_queue_right <= mem[rd_ptr][WIDTH-1:0];
        end else if (mute) begin
            send_queue_left  <= '0;
            send_queue_right <= '0;
        end
    end

`ifdef I2S_FEEDER_UNDERRUN_EN
    // primed arms mute insertion only once real audio has started
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            primed       <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (pop) primed <= 1'b1;
            if (mute && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
        end
    end

    assign underruns = underrun_cnt;
`else
    assign underruns = 8'd0;
`endif

endmodule

// File: tb/tb_i2s_feeder.sv
// tb_i2s_feeder: directed stimulus with a scoreboard queue of expected frames;
// a monitor pops and compares on every send pulse.
module tb_i2s_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        in_ready;
    logic        i2s_ready;
    logic        send;
    logic [15:0] send_queue_left;
    logic [15:0] send_queue_right;
    logic [2:0]  count;
    logic [7:0]  underruns;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] exp_q[$];

    i2s_feeder #(.WIDTH(16), .DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_left          (in_left),
        .in_right         (in_right),
        .in_ready         (in_ready),
        .i2s_ready        (i2s_ready),
        .send             (send),
        .send_queue_left  (send_queue_left),
        .send_queue_right (send_queue_right),
        .count            (count),
        .underruns        (underruns)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_left   = '0;
        in_right  = '0;
        i2s_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r, input bit expect_out);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        if (expect_out) exp_q.push_back({l, r});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_send(input int budget);
        int n = 0;
        while (send !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("send_timeout", {31'd0, send}, 32'd1);
    endtask

    // monitor: every send pulse must match the oldest expected frame
    initial begin
        forever begin
            @(negedge clk);
            if (send === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_send", {send_queue_left, send_queue_right}, 32'hFFFF_FFFF);
                end else begin
                    chk("send_data", {send_queue_left, send_queue_right}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        do_reset();
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_send",      32'(send),      32'd0);
        chk("rst_sq",        {send_queue_left, send_queue_right}, 32'd0);
        chk("rst_underruns", 32'(underruns), 32'd0);

        // latency: write at edge N, pop at N+1, send during the following cycle
        i2s_ready = 1'b1;
        push_frame(16'd7, 16'd13, 1'b1);
        chk("lat_count_n",  32'(count), 32'd1);
        chk("lat_send_n",   32'(send),  32'd0);
        tick();
        chk("lat_send_n1",  32'(send),  32'd1);
        chk("lat_left",     32'(send_queue_left),  32'd7);
        chk("lat_right",    32'(send_queue_right), 32'd13);
        chk("lat_count_n1", 32'(count), 32'd0);
        tick();
        chk("lat_pulse_end", 32'(send), 32'd0);
        i2s_ready = 1'b0;
        repeat (2) tick();

        // fill to DEPTH with transmitter stalled, fifth frame refused
        do_reset();
        push_frame(16'd1, 16'd2, 1'b1);
        push_frame(16'd3, 16'd4, 1'b1);
        push_frame(16'd5, 16'd6, 1'b1);
        push_frame(16'd7, 16'd8, 1'b1);
        chk("full_count",    32'(count),    32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        push_frame(16'd99, 16'd99, 1'b0);
        chk("full_ignored",  32'(count),    32'd4);
        for (int f = 0; f < 4; f++) begin
            i2s_ready = 1'b1;
            wait_send(10);
            i2s_ready = 1'b0;
            repeat (2) tick();
        end
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_q",     exp_q.size(), 32'd0);

        // simultaneous push/pop, then transmitter busy for 10 cycles
        do_reset();
        i2s_ready = 1'b1;
        push_frame(16'h11, 16'h22, 1'b1);
        push_frame(16'h33, 16'h44, 1'b1);
        chk("pushpop_count", 32'(count), 32'd1);
        chk("pushpop_send",  32'(send),  32'd1);
        tick();
        i2s_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("busy_no_send", 32'(send), 32'd0);
        end
        i2s_ready = 1'b1;
        tick();
        chk("ready_rise_idle", 32'(send), 32'd0);
        tick();
        chk("ready_rise_send", 32'(send), 32'd1);
        chk("second_left",     32'(send_queue_left), 32'h33);
        i2s_ready = 1'b0;
        repeat (2) tick();
        chk("second_q", exp_q.size(), 32'd0);

        // FIFO runs dry after one frame with the transmitter ready
        do_reset();
        i2s_ready = 1'b1;
        push_frame(16'd5, 16'd9, 1'b1);
        wait_send(5);
        i2s_ready = 1'b0;
        repeat (2) tick();
        i2s_ready = 1'b1;
`ifdef I2S_FEEDER_UNDERRUN_EN
        exp_q.push_back(32'd0);
        tick();
        tick();
        chk("under_send",  32'(send),      32'd1);
        chk("under_count", 32'(underruns), 32'd1);
        chk("under_sq",    {send_queue_left, send_queue_right}, 32'd0);
        i2s_ready = 1'b0;
        repeat (2) tick();
`else
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("dry_no_send", 32'(send), 32'd0);
        end
        chk("dry_underruns", 32'(underruns), 32'd0);
        i2s_ready = 1'b0;
`endif
        chk("dry_q", exp_q.size(), 32'd0);

        // asynchronous reset in WAIT_BUSY with 3 frames queued
        do_reset();
        i2s_ready = 1'b1;
        push_frame(16'hA1, 16'hB1, 1'b1);
        push_frame(16'hA2, 16'hB2, 1'b0);
        push_frame(16'hA3, 16'hB3, 1'b0);
        push_frame(16'hA4, 16'hB4, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_sq",    32'(send_queue_left), 32'hA1);
        reset = 1'b0;
        #1;
        chk("async_count",    32'(count),    32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_send",     32'(send),     32'd0);
        chk("async_sq",       {send_queue_left, send_queue_right}, 32'd0);
        chk("async_underrun", 32'(underruns), 32'd0);
        tick();
        reset = 1'b1;
        repeat (10) tick();
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_q",     exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/i2s_feeder.md
I2S_FEEDER -- requirements
Module: i2s_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width per channel, equal to the transmitter's send_queue_left/right width.
REQ-002 SHALL have parameter DEPTH, default 4: stereo-frame FIFO depth, a power of two and at least 2.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port in_valid  input  1: upstream stereo frame present.
REQ-006 SHALL have port in_left  input  WIDTH: upstream left sample.
REQ-007 SHALL have port in_right  input  WIDTH: upstream right sample.
REQ-008 SHALL have port in_ready  output  1: FIFO can accept a frame.
REQ-009 SHALL have port i2s_ready  input  1: transmitter ready level, connected to the transmitter's ready output.
REQ-010 SHALL have port send  output  1: one-cycle start pulse to the transmitter.
REQ-011 SHALL have port send_queue_left  output  WIDTH: left sample presented to the transmitter.
REQ-012 SHALL have port send_queue_right  output  WIDTH: right sample presented to the transmitter.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1: number of frames currently held in the FIFO.
REQ-014 SHALL have port underruns  output  8: underrun event counter; the output is driven 0 when the feature is compiled out (REQ-030).

Function
REQ-015 SHALL define in_ready = (count != DEPTH), driven combinationally from registered state.
REQ-016 SHALL write {in_left, in_right} into the FIFO on a rising edge where in_valid && in_ready.
REQ-017 SHALL NOT bypass the FIFO: a frame written at edge N is poppable no earlier than edge N+1.
REQ-018 SHALL sequence transfers with a state machine having states IDLE, SEND, WAIT_BUSY and WAIT_READY.
REQ-019 IDLE->SEND SHALL occur on an edge where i2s_ready=1 and count!=0; on that edge the head frame is popped into send_queue_left/right.
REQ-020 In SEND, send SHALL be 1 for exactly that cycle; the state then moves to WAIT_BUSY unconditionally.
REQ-021 WAIT_BUSY->WAIT_READY SHALL occur when i2s_ready=0.
REQ-022 WAIT_READY->IDLE SHALL occur when i2s_ready=1.
REQ-023 send_queue_left/right SHALL hold their value from the pop until the next pop.
REQ-024 Latency SHALL be as follows: write into an empty FIFO at edge N with i2s_ready=1 gives pop at edge N+1 and send=1 during the cycle after edge N+1.
REQ-025 A simultaneous push and pop SHALL leave count unchanged; a push while full SHALL be impossible (in_ready=0); a pop while empty SHALL NOT occur.
REQ-026 The FIFO read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 While reset=0, SHALL force: state=IDLE, FIFO pointers=0, count=0, send=0, send_queue_left=0, send_queue_right=0, underruns=0, primed=0.
REQ-028 Asserting reset mid-transfer SHALL discard all FIFO contents and any transfer in progress.
REQ-029 After reset deasserts, the first send SHALL be emitted only after a real frame has been pushed.

Configuration
REQ-030 Macro I2S_FEEDER_UNDERRUN_EN SHALL enable underrun handling, as follows:
- primed flag: set on the first pop after reset.
- Trigger condition: state=IDLE, primed=1, i2s_ready=1 and count=0.
- Action: enter SEND with send_queue_left/right loaded with 0 (a mute frame).
- Counter: underruns increments by 1, saturating at 255.
REQ-031 Without I2S_FEEDER_UNDERRUN_EN, the feeder SHALL stay in IDLE while the FIFO is empty, and underruns SHALL be constant 0.

Verification
REQ-032 Push L=7, R=13 into an empty FIFO with i2s_ready=1 -> one-cycle send pulse two edges after the write, with send_queue_left=7 and send_queue_right=13.
REQ-033 Hold i2s_ready=0 and push 4 frames (DEPTH=4) -> count=4, in_ready=0; a fifth in_valid is ignored; the frames later drain in order.
REQ-034 i2s_ready low for 10 cycles after send, then high -> no second send until IDLE is re-entered; the next frame's send follows the rising edge of i2s_ready.
REQ-035 Macro defined, one frame sent, FIFO then empty with i2s_ready=1 -> send with 0/0 values, and underruns=1.
REQ-036 Macro undefined, same stimulus as REQ-035 -> no send, and underruns=0.
REQ-037 reset=0 asserted asynchronously mid-WAIT_BUSY with 3 frames queued -> all outputs 0 and count=0 immediately, without waiting for a clock edge.
